// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key tracker: receiver states, prefix bytes,
// mapped scan codes and key bit positions.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_e;

    localparam int unsigned BYTE_W   = 8;
    localparam int unsigned NUM_KEYS = 4;

    localparam logic [7:0] CODE_EXT    = 8'hE0;
    localparam logic [7:0] CODE_BRK    = 8'hF0;
    localparam logic [7:0] CODE_LEFT   = 8'h6B;  // extended
    localparam logic [7:0] CODE_RIGHT  = 8'h74;  // extended
    localparam logic [7:0] CODE_LSHIFT = 8'h12;
    localparam logic [7:0] CODE_Z      = 8'h1A;

    localparam int unsigned KEY_LEFT  = 0;
    localparam int unsigned KEY_RIGHT = 1;
    localparam int unsigned KEY_JUMP  = 2;
    localparam int unsigned KEY_SHOOT = 3;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronizes the bus, samples on ps2_clk falling edges and
// reports each complete frame. Define PS2_PARITY_CHECK_EN to reject even-parity frames.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic              clk,
    input  logic              clrn,
    input  logic              ps2_clk,
    input  logic              ps2_data,
    output logic [BYTE_W-1:0] rx_byte,
    output logic              rx_valid_c,
    output logic              rx_err_c
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   fall_c;
    logic                   data_s;
    logic                   stop_ok_c;
    logic                   timeout_c;
    rx_state_e              state, state_nx;
    logic [2:0]             bit_cnt;
    logic [TMO_W-1:0]       tmo_cnt;

    // Synchronizers reset to the idle-high bus level so release makes no false edge
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
            clk_prev  <= clk_sync[SYNC_STAGES-1];
        end
    end

    assign fall_c    = clk_prev & ~clk_sync[SYNC_STAGES-1];
    assign data_s    = data_sync[SYNC_STAGES-1];
    assign timeout_c = (state != ST_IDLE) && !fall_c &&
                       (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_CHECK_EN
    logic par_ok;

    // Odd parity over data bits plus parity bit, captured on the parity edge
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            par_ok <= 1'b0;
        else if (fall_c && state == ST_PARITY)
            par_ok <= ^{rx_byte, data_s};
    end

    assign stop_ok_c = data_s & par_ok;
`else
    assign stop_ok_c = data_s;
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        rx_valid_c = 1'b0;
        rx_err_c   = 1'b0;
        if (timeout_c) begin
            state_nx = ST_IDLE;
            rx_err_c = 1'b1;
        end else if (fall_c) begin
            case (state)
                ST_IDLE:   if (!data_s) state_nx = ST_DATA;
                ST_DATA:   if (bit_cnt == 3'd7) state_nx = ST_PARITY;
                ST_PARITY: state_nx = ST_STOP;
                ST_STOP: begin
                    state_nx   = ST_IDLE;
                    rx_valid_c = stop_ok_c;
                    rx_err_c   = ~stop_ok_c;
                end
                default:   state_nx = ST_IDLE;
            endcase
        end
    end

    // Bit counter, LSB-first shifter and idle-gap counter
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bit_cnt <= 3'd0;
            rx_byte <= '0;
            tmo_cnt <= '0;
        end else begin
            if (state == ST_IDLE || fall_c) tmo_cnt <= '0;
            else                            tmo_cnt <= tmo_cnt + TMO_W'(1);

            if (fall_c && state == ST_IDLE) begin
                bit_cnt <= 3'd0;
            end else if (fall_c && state == ST_DATA) begin
                rx_byte <= {data_s, rx_byte[BYTE_W-1:1]};
                if (bit_cnt != 3'd7) bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// Tracks the held state of four game keys from a PS/2 keyboard scan-code stream.
// Define PS2_PARITY_CHECK_EN to discard frames with bad parity.
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic                clk,
    input  logic                clrn,
    input  logic                ps2_clk,
    input  logic                ps2_data,
    output logic [NUM_KEYS-1:0] keys,
    output logic [BYTE_W-1:0]   code,
    output logic                code_valid,
    output logic                frame_err
);

    logic [BYTE_W-1:0] rx_byte;
    logic              rx_valid_c;
    logic              rx_err_c;
    logic              ext;
    logic              brk;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_rx (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (rx_byte),
        .rx_valid_c (rx_valid_c),
        .rx_err_c   (rx_err_c)
    );

    // Prefix bytes arm ext/brk; any other byte consumes them
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            keys       <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
            ext        <= 1'b0;
            brk        <= 1'b0;
        end else begin
            code_valid <= rx_valid_c;
            frame_err  <= rx_err_c;
            if (rx_valid_c) begin
                code <= rx_byte;
                if (rx_byte == CODE_EXT) begin
                    ext <= 1'b1;
                end else if (rx_byte == CODE_BRK) begin
                    brk <= 1'b1;
                end else begin
                    ext <= 1'b0;
                    brk <= 1'b0;
                    if (ext && rx_byte == CODE_LEFT)    keys[KEY_LEFT]  <= ~brk;
                    if (ext && rx_byte == CODE_RIGHT)   keys[KEY_RIGHT] <= ~brk;
                    if (!ext && rx_byte == CODE_LSHIFT) keys[KEY_JUMP]  <= ~brk;
                    if (!ext && rx_byte == CODE_Z)      keys[KEY_SHOOT] <= ~brk;
                end
            end
        end
    end

endmodule

// File: doc/ps2_key_tracker.md
PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100000, mid-frame idle limit in clk cycles (1 ms at 100 MHz).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on ps2_clk and ps2_data (minimum 2).
REQ-003 SHALL have port clk  input  1  system clock; the block's only clock.
REQ-004 SHALL have port clrn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ps2_clk  input  1  raw keyboard clock, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  raw keyboard data, asynchronous to clk.
REQ-007 SHALL have port keys  output  4  held state: [0] left arrow, [1] right arrow, [2] left Shift (jump), [3] Z (shoot).
REQ-008 SHALL have port code  output  8  last accepted scan byte.
REQ-009 SHALL have port code_valid  output  1  one-cycle pulse when code updates.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse on a discarded frame.

Function
REQ-011 SHALL synchronize ps2_clk/ps2_data through SYNC_STAGES flops; all logic uses synchronized copies only.
REQ-012 SHALL detect a ps2_clk falling edge as synced previous=1, current=0; one sample of ps2_data per edge.
REQ-013 SHALL run receiver FSM IDLE -> DATA (8 bits, LSB first) -> PARITY -> STOP -> IDLE.
REQ-014 IDLE: edge with data=0 -> DATA, bit counter 0; edge with data=1 -> stay IDLE, no error.
REQ-015 DATA: shift bit in per edge; after the 8th bit -> PARITY; counter 3 bits, no wrap beyond 7.
REQ-016 STOP: edge with data=1 -> accept byte; data=0 -> discard, pulse frame_err; both -> IDLE.
REQ-017 SHALL count clk cycles since last edge while not IDLE; at TIMEOUT_CYCLES -> IDLE, discard, pulse frame_err.
REQ-018 On accept, code and code_valid SHALL update on the clk edge after the one that registers the stop-bit falling edge.
REQ-019 Decoder: byte 0xE0 sets ext flag; 0xF0 sets brk flag; neither changes keys.
REQ-020 Other bytes: match {ext,byte} against {1,0x6B},{1,0x74},{0,0x12},{0,0x1A}; on match keys[i] <= ~brk.
REQ-021 keys SHALL update on the same clk edge as code_valid; ext and brk clear after any non-prefix byte, matched or not.
REQ-022 Unmapped bytes (incl. 0xE1, 0xAA, 0xFA) SHALL leave keys unchanged.
REQ-023 Keys SHALL be independent; any combination may be held; repeated makes keep bit at 1.
REQ-024 A discarded frame SHALL NOT alter ext, brk, keys or code.

Reset
REQ-025 clrn low SHALL asynchronously force FSM IDLE, counters 0, ext=brk=0, keys=0, code=0x00, code_valid=0, frame_err=0.
REQ-026 Reset mid-frame SHALL abandon the partial frame; reception resumes at the next start bit after release.
REQ-027 Synchronizer flops SHALL reset to 1 (bus idle) so release creates no false edge.

Configuration
REQ-028 With PS2_PARITY_CHECK_EN defined, PARITY SHALL require odd parity over 8 data bits + parity bit; failure discards at STOP and pulses frame_err.
REQ-029 Without PS2_PARITY_CHECK_EN, parity bit SHALL be sampled and ignored; no parity logic synthesized.

Structure
REQ-030 Package ps2_pkg SHALL hold FSM state enum, prefix codes 0xE0/0xF0, four mapped scan codes, key index constants.
REQ-031 Frame reception (REQ-011..018) SHALL be sub-module ps2_rx outputting byte and pulse; decoder lives in ps2_key_tracker.

Verification
REQ-032 Send 0x1A, then 0xF0,0x1A (valid parity) -> keys=4'b1000 after first frame, 4'b0000 after third; code_valid pulses thrice.
REQ-033 Send 0xE0,0x6B then 0x12 -> keys=4'b0101; then 0xE0,0xF0,0x6B -> keys=4'b0100.
REQ-034 Send 0x1A with stop bit 0 -> frame_err one pulse, code_valid 0, keys unchanged.
REQ-035 Send 0x1A with even parity -> PS2_PARITY_CHECK_EN: frame_err, keys=0; without: keys[3]=1.
REQ-036 Stop ps2_clk after 4 data bits for TIMEOUT_CYCLES -> frame_err pulse, FSM IDLE; next valid 0x74 with prior 0xE0 sets keys[1].
REQ-037 Assert clrn low mid-frame with keys=4'b1111 -> all outputs 0 immediately; first full frame after release decodes correctly.
